// File: rtl/regfile_pkg.sv
// Shared constants for the MIPS general-purpose register file: geometry and
// the architectural register numbers that benches refer to by name.
package regfile_pkg;
  localparam int REG_NUM_W = 5;
  localparam int NUM_REGS  = 32;
  localparam int WORD_W    = 32;

  localparam logic [REG_NUM_W-1:0] ZERO_REG = 5'd0;
  localparam logic [REG_NUM_W-1:0] REG_AT   = 5'd1;
  localparam logic [REG_NUM_W-1:0] REG_V0   = 5'd2;
  localparam logic [REG_NUM_W-1:0] REG_SP   = 5'd29;
  localparam logic [REG_NUM_W-1:0] REG_RA   = 5'd31;
endpackage

// File: rtl/regfile_if.sv
// Read/write port bundle between the register file and its user (decode/ALU).
// There is no valid/ready pair: reads are combinational and always valid, and
// a write is a single-cycle strobe (rd_write_enable) consumed at the rising
// edge with no back-pressure.
interface regfile_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rs_num;
  logic [ADDR_W-1:0] rt_num;
  logic [WIDTH-1:0]  rs_data;
  logic [WIDTH-1:0]  rt_data;
  logic [ADDR_W-1:0] rd_num;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_write_enable;

  modport master (
    output rs_num, rt_num, rd_num, rd_data, rd_write_enable,
    input  rs_data, rt_data
  );

  modport slave (
    input  rs_num, rt_num, rd_num, rd_data, rd_write_enable,
    output rs_data, rt_data
  );
endinterface

// File: rtl/regfile_register_we.sv
// One WIDTH-bit architectural register with synchronous active-high clear
// and a load enable; clear wins over a simultaneous load.
module register_we #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (we_i) data_d = d_i;
  end

  always_ff @(posedge clock) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q_o = data_q;
endmodule

// File: rtl/regfile.sv
// 32 x 32-bit MIPS register file: two combinational read ports, one clocked
// write port, $0 hardwired to zero, optional write-through bypass.
module regfile #(
  parameter int WIDTH    = regfile_pkg::WORD_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = regfile_pkg::REG_NUM_W,
  parameter int BYPASS   = 0
) (
  input  logic       clock,
  input  logic       reset,
  regfile_if.slave   bus
);
  import regfile_pkg::*;

  localparam logic [ADDR_W-1:0] ZERO_NUM = ADDR_W'(ZERO_REG);

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:1] we;
  logic                wr_active;

  assign wr_active = bus.rd_write_enable && (bus.rd_num != ZERO_NUM);

  always_comb begin
    we = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (wr_active && (bus.rd_num == ADDR_W'(i))) we[i] = 1'b1;
    end
  end

  // $0 is a constant so neither reset nor a write can ever disturb it.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    if (g == 0) begin : g_zero
      assign regs[g] = '0;
    end else begin : g_reg
      register_we #(.WIDTH(WIDTH)) u_reg (
        .clock (clock),
        .reset (reset),
        .we_i  (we[g]),
        .d_i   (bus.rd_data),
        .q_o   (regs[g])
      );
    end
  end

  // Bypass is gated off during reset so reads then show stored contents.
  always_comb begin
    bus.rs_data = regs[bus.rs_num];
    bus.rt_data = regs[bus.rt_num];
    if ((BYPASS != 0) && !reset && wr_active) begin
      if (bus.rs_num == bus.rd_num) bus.rs_data = bus.rd_data;
      if (bus.rt_num == bus.rd_num) bus.rt_data = bus.rd_data;
    end
  end
endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: one instance without bypass (dut0) and one with
// bypass (dut1), both fed the same stimulus and checked against fixed values.
module tb_regfile;
  import regfile_pkg::*;

  logic        clock;
  logic        reset;
  logic [4:0]  rs_num, rt_num, rd_num;
  logic [31:0] rd_data;
  logic        rd_we;

  int tests_run    = 0;
  int tests_failed = 0;

  regfile_if #(.WIDTH(32), .ADDR_W(5)) bus0 ();
  regfile_if #(.WIDTH(32), .ADDR_W(5)) bus1 ();

  assign bus0.rs_num = rs_num;  assign bus1.rs_num = rs_num;
  assign bus0.rt_num = rt_num;  assign bus1.rt_num = rt_num;
  assign bus0.rd_num = rd_num;  assign bus1.rd_num = rd_num;
  assign bus0.rd_data = rd_data; assign bus1.rd_data = rd_data;
  assign bus0.rd_write_enable = rd_we; assign bus1.rd_write_enable = rd_we;

  regfile #(.WIDTH(32), .NUM_REGS(32), .ADDR_W(5), .BYPASS(0)) dut0 (
    .clock (clock), .reset (reset), .bus (bus0)
  );
  regfile #(.WIDTH(32), .NUM_REGS(32), .ADDR_W(5), .BYPASS(1)) dut1 (
    .clock (clock), .reset (reset), .bus (bus1)
  );

  // clock/reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // driver tasks: inputs change 1ns after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [4:0] num, input logic [31:0] data);
    rd_num  = num;
    rd_data = data;
    rd_we   = 1'b1;
    tick();
    rd_we   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    do_write(5'd5, 32'hDEADBEEF);
    rs_num = 5'd5;
    #1;
    tests_run++;
    if (bus0.rs_data !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL pre_reset_r5: got %h expected %h", bus0.rs_data, 32'hDEADBEEF);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    tests_run++;
    if (bus0.rs_data !== 32'h0 || bus1.rs_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_r5: got %h/%h expected 0", bus0.rs_data, bus1.rs_data);
    end
    for (int a = 0; a < 32; a++) begin
      rs_num = a[4:0];
      rt_num = 5'(31 - a);
      #1;
      tests_run++;
      if (bus0.rs_data !== 32'h0 || bus0.rt_data !== 32'h0 ||
          bus1.rs_data !== 32'h0 || bus1.rt_data !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_all a=%0d: got %h %h %h %h expected 0",
                 a, bus0.rs_data, bus0.rt_data, bus1.rs_data, bus1.rt_data);
      end
    end
  endtask

  task automatic test_dual_port();
    do_write(5'd3, 32'h00000007);
    do_write(5'd4, 32'hFFFFFFF9);
    rs_num = 5'd0;
    rt_num = 5'd0;
    #2;
    rs_num = 5'd3;
    rt_num = 5'd4;
    #1;
    tests_run++;
    if (bus0.rs_data !== 32'h00000007 || bus0.rt_data !== 32'hFFFFFFF9) begin
      tests_failed++;
      $display("FAIL dual_port: got %h %h expected 00000007 fffffff9",
               bus0.rs_data, bus0.rt_data);
    end
    rt_num = 5'd3;
    #1;
    tests_run++;
    if (bus0.rs_data !== 32'h00000007 || bus0.rt_data !== 32'h00000007) begin
      tests_failed++;
      $display("FAIL same_reg_both_ports: got %h %h expected 00000007",
               bus0.rs_data, bus0.rt_data);
    end
  endtask

  task automatic test_zero_reg();
    rs_num  = 5'd0;
    rt_num  = 5'd0;
    rd_num  = 5'd0;
    rd_data = 32'h12345678;
    rd_we   = 1'b1;
    #1;
    tests_run++;
    if (bus1.rs_data !== 32'h0 || bus1.rt_data !== 32'h0 || bus0.rs_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL zero_bypass: got %h %h %h expected 0",
               bus1.rs_data, bus1.rt_data, bus0.rs_data);
    end
    tick();
    rd_we = 1'b0;
    #1;
    tests_run++;
    if (bus0.rs_data !== 32'h0 || bus1.rs_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL zero_after_write: got %h %h expected 0", bus0.rs_data, bus1.rs_data);
    end
  endtask

  task automatic test_we_low();
    do_write(5'd7, 32'h0000AAAA);
    rd_num  = 5'd7;
    rd_data = 32'h00005555;
    rd_we   = 1'b0;
    rs_num  = 5'd7;
    #1;
    tests_run++;
    if (bus1.rs_data !== 32'h0000AAAA) begin
      tests_failed++;
      $display("FAIL we_low_no_bypass: got %h expected 0000aaaa", bus1.rs_data);
    end
    repeat (3) tick();
    tests_run++;
    if (bus0.rs_data !== 32'h0000AAAA || bus1.rs_data !== 32'h0000AAAA) begin
      tests_failed++;
      $display("FAIL we_low_hold: got %h %h expected 0000aaaa", bus0.rs_data, bus1.rs_data);
    end
  endtask

  task automatic test_same_cycle();
    do_write(5'd9, 32'h11111111);
    rd_num  = 5'd9;
    rd_data = 32'h22222222;
    rd_we   = 1'b1;
    rs_num  = 5'd9;
    rt_num  = 5'd9;
    #1;
    tests_run++;
    if (bus0.rs_data !== 32'h11111111) begin
      tests_failed++;
      $display("FAIL same_cycle_nobypass: got %h expected 11111111", bus0.rs_data);
    end
    tests_run++;
    if (bus1.rs_data !== 32'h22222222 || bus1.rt_data !== 32'h22222222) begin
      tests_failed++;
      $display("FAIL same_cycle_bypass: got %h %h expected 22222222",
               bus1.rs_data, bus1.rt_data);
    end
    tick();
    rd_we = 1'b0;
    #1;
    tests_run++;
    if (bus0.rs_data !== 32'h22222222 || bus1.rs_data !== 32'h22222222) begin
      tests_failed++;
      $display("FAIL same_cycle_after: got %h %h expected 22222222",
               bus0.rs_data, bus1.rs_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  nums [4];
    logic [31:0] vals [4];
    nums = '{REG_AT, REG_V0, REG_SP, REG_RA};
    vals = '{32'hA5A5A5A5, 32'h0000FFFF, 32'h7FFFFFF0, 32'h80000004};
    for (int i = 0; i < 4; i++) begin
      rd_num  = nums[i];
      rd_data = vals[i];
      rd_we   = 1'b1;
      tick();
    end
    rd_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rs_num = nums[i];
      rt_num = nums[3 - i];
      #1;
      tests_run++;
      if (bus0.rs_data !== vals[i] || bus0.rt_data !== vals[3 - i] ||
          bus1.rs_data !== vals[i]) begin
        tests_failed++;
        $display("FAIL back_to_back r%0d/r%0d: got %h %h %h expected %h %h",
                 nums[i], nums[3 - i], bus0.rs_data, bus0.rt_data, bus1.rs_data,
                 vals[i], vals[3 - i]);
      end
    end
  endtask

  task automatic test_collision();
    rs_num  = REG_RA;
    reset   = 1'b1;
    rd_num  = REG_RA;
    rd_data = 32'hCAFEF00D;
    rd_we   = 1'b1;
    #1;
    tests_run++;
    if (bus1.rs_data !== 32'h80000004) begin
      tests_failed++;
      $display("FAIL reset_suppresses_bypass: got %h expected 80000004", bus1.rs_data);
    end
    tick();
    reset = 1'b0;
    rd_we = 1'b0;
    #1;
    tests_run++;
    if (bus0.rs_data !== 32'h0 || bus1.rs_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_write_collision: got %h %h expected 0",
               bus0.rs_data, bus1.rs_data);
    end
  endtask

  initial begin
    reset   = 1'b1;
    rs_num  = '0;
    rt_num  = '0;
    rd_num  = '0;
    rd_data = '0;
    rd_we   = 1'b0;
    test_reset();
    test_dual_port();
    test_zero_reg();
    test_we_low();
    test_same_cycle();
    test_back_to_back();
    test_collision();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
